// File: rtl/ace_snoop_fanout.sv
// ACE snoop fan-out: broadcasts one snoop at a time to the cached masters' AC
// channels, collects every CRRESP and returns one merged response plus data source.
module ace_snoop_fanout #(
    parameter int unsigned NoMst     = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxWidth  = (NoMst > 1) ? $clog2(NoMst) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   snp_req_valid_i,
    output logic                   snp_req_ready_o,
    input  logic [AddrWidth-1:0]   snp_addr_i,
    input  logic [3:0]             snp_snoop_i,
    input  logic [NoMst-1:0]       snp_excl_i,
    output logic [NoMst-1:0]       ac_valid_o,
    input  logic [NoMst-1:0]       ac_ready_i,
    output logic [AddrWidth-1:0]   ac_addr_o,
    output logic [3:0]             ac_snoop_o,
    input  logic [NoMst-1:0]       cr_valid_i,
    output logic [NoMst-1:0]       cr_ready_o,
    input  logic [5*NoMst-1:0]     cr_resp_i,
    output logic                   snp_resp_valid_o,
    input  logic                   snp_resp_ready_i,
    output logic [4:0]             snp_resp_o,
    output logic                   data_src_valid_o,
    output logic [IdxWidth-1:0]    data_src_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [AddrWidth-1:0]  r_addr;
    logic [3:0]            r_snoop;
    logic [NoMst-1:0]      r_target;
    logic [NoMst-1:0]      r_ac_done;
    logic [NoMst-1:0]      r_cr_done;
    logic [4:0]            r_acc;
    logic                  r_src_valid;
    logic [IdxWidth-1:0]   r_src;

    logic                  w_req_hs;
    logic [NoMst-1:0]      w_target_new;
    logic [NoMst-1:0]      w_ac_valid;
    logic [NoMst-1:0]      w_cr_ready;
    logic [NoMst-1:0]      w_ac_hs;
    logic [NoMst-1:0]      w_cr_hs;
    logic [4:0]            w_cr_merge;
    logic                  w_dt_any;
    logic [IdxWidth-1:0]   w_dt_idx;

    // Handshake-facing outputs decode only from registered state so no
    // combinational path exists from any valid/ready input to an output.
    assign w_ac_valid   = (r_state == SNOOP) ? (r_target & ~r_ac_done) : '0;
    assign w_cr_ready   = (r_state == SNOOP) ? (r_ac_done & ~r_cr_done) : '0;
    assign w_ac_hs      = w_ac_valid & ac_ready_i;
    assign w_cr_hs      = w_cr_ready & cr_valid_i;
    assign w_req_hs     = (r_state == IDLE) && snp_req_valid_i;
    assign w_target_new = ~snp_excl_i;

    // Merge all accepted responses; the descending scan leaves the lowest
    // DataTransfer index as the winner.
    always_comb begin
        w_cr_merge = '0;
        w_dt_any   = 1'b0;
        w_dt_idx   = '0;
        for (int i = NoMst - 1; i >= 0; i--) begin
            if (w_cr_hs[i]) begin
                w_cr_merge = w_cr_merge | cr_resp_i[5*i +: 5];
                if (cr_resp_i[5*i]) begin
                    w_dt_any = 1'b1;
                    w_dt_idx = IdxWidth'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_hs) begin
                    w_state_next = (w_target_new == '0) ? RESP : SNOOP;
                end
            end
            SNOOP: begin
                if ((r_cr_done | w_cr_hs) == r_target) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (snp_resp_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr      <= '0;
            r_snoop     <= '0;
            r_target    <= '0;
            r_ac_done   <= '0;
            r_cr_done   <= '0;
            r_acc       <= '0;
            r_src_valid <= 1'b0;
            r_src       <= '0;
        end else begin
            if (w_req_hs) begin
                r_addr      <= snp_addr_i;
                r_snoop     <= snp_snoop_i;
                r_target    <= w_target_new;
                r_ac_done   <= '0;
                r_cr_done   <= '0;
                r_acc       <= '0;
                r_src_valid <= 1'b0;
                r_src       <= '0;
            end else if (r_state == SNOOP) begin
                r_ac_done <= r_ac_done | w_ac_hs;
                r_cr_done <= r_cr_done | w_cr_hs;
                r_acc     <= r_acc | w_cr_merge;
                if (!r_src_valid && w_dt_any) begin
                    r_src_valid <= 1'b1;
                    r_src       <= w_dt_idx;
                end
            end
        end
    end

    // Ready is forced low while reset is asserted, not just after the first edge.
    assign snp_req_ready_o  = (r_state == IDLE) && rst_ni;
    assign ac_valid_o       = w_ac_valid;
    assign cr_ready_o       = w_cr_ready;
    assign ac_addr_o        = r_addr;
    assign ac_snoop_o       = r_snoop;
    assign snp_resp_valid_o = (r_state == RESP);
    assign snp_resp_o       = (r_state == RESP) ? r_acc : '0;
    assign data_src_valid_o = (r_state == RESP) && r_src_valid;
    assign data_src_o       = (r_state == RESP) ? r_src : '0;

endmodule

// File: tb/tb_ace_snoop_fanout.sv
// Directed self-checking bench for ace_snoop_fanout with two snooped masters.
module tb_ace_snoop_fanout;

    localparam int NoMst     = 2;
    localparam int AddrWidth = 64;
    localparam int IdxWidth  = 1;

    logic                 clk_i;
    logic                 rst_ni;
    logic                 snp_req_valid_i;
    logic                 snp_req_ready_o;
    logic [AddrWidth-1:0] snp_addr_i;
    logic [3:0]           snp_snoop_i;
    logic [NoMst-1:0]     snp_excl_i;
    logic [NoMst-1:0]     ac_valid_o;
    logic [NoMst-1:0]     ac_ready_i;
    logic [AddrWidth-1:0] ac_addr_o;
    logic [3:0]           ac_snoop_o;
    logic [NoMst-1:0]     cr_valid_i;
    logic [NoMst-1:0]     cr_ready_o;
    logic [5*NoMst-1:0]   cr_resp_i;
    logic                 snp_resp_valid_o;
    logic                 snp_resp_ready_i;
    logic [4:0]           snp_resp_o;
    logic                 data_src_valid_o;
    logic [IdxWidth-1:0]  data_src_o;

    int checks   = 0;
    int failures = 0;

    ace_snoop_fanout #(
        .NoMst     (NoMst),
        .AddrWidth (AddrWidth)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .snp_req_valid_i  (snp_req_valid_i),
        .snp_req_ready_o  (snp_req_ready_o),
        .snp_addr_i       (snp_addr_i),
        .snp_snoop_i      (snp_snoop_i),
        .snp_excl_i       (snp_excl_i),
        .ac_valid_o       (ac_valid_o),
        .ac_ready_i       (ac_ready_i),
        .ac_addr_o        (ac_addr_o),
        .ac_snoop_o       (ac_snoop_o),
        .cr_valid_i       (cr_valid_i),
        .cr_ready_o       (cr_ready_o),
        .cr_resp_i        (cr_resp_i),
        .snp_resp_valid_o (snp_resp_valid_o),
        .snp_resp_ready_i (snp_resp_ready_i),
        .snp_resp_o       (snp_resp_o),
        .data_src_valid_o (data_src_valid_o),
        .data_src_o       (data_src_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_resp(input string tag, input logic vld, input logic [4:0] resp,
                              input logic src_vld, input logic src);
        check({tag, ".resp_valid"}, 64'(snp_resp_valid_o), 64'(vld));
        check({tag, ".resp"},       64'(snp_resp_o),       64'(resp));
        check({tag, ".src_valid"},  64'(data_src_valid_o), 64'(src_vld));
        check({tag, ".src"},        64'(data_src_o),       64'(src));
    endtask

    task automatic request(input logic [63:0] addr, input logic [3:0] snoop, input logic [1:0] excl);
        snp_req_valid_i = 1'b1;
        snp_addr_i      = addr;
        snp_snoop_i     = snoop;
        snp_excl_i      = excl;
    endtask

    initial begin
        rst_ni           = 1'b0;
        snp_req_valid_i  = 1'b0;
        snp_addr_i       = '0;
        snp_snoop_i      = '0;
        snp_excl_i       = '0;
        ac_ready_i       = '0;
        cr_valid_i       = '0;
        cr_resp_i        = '0;
        snp_resp_ready_i = 1'b0;

        // Reset state
        #12;
        check("rst.req_ready", 64'(snp_req_ready_o), 64'd0);
        check("rst.ac_valid",  64'(ac_valid_o),      64'd0);
        check("rst.cr_ready",  64'(cr_ready_o),      64'd0);
        check("rst.ac_addr",   ac_addr_o,            64'd0);
        check("rst.ac_snoop",  64'(ac_snoop_o),      64'd0);
        check_resp("rst", 1'b0, 5'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        #1;
        check("rel.req_ready", 64'(snp_req_ready_o), 64'd1);

        // T1: master0 excluded, ReadShared to 0x1000
        request(64'h1000, 4'b0001, 2'b01);
        tick();
        snp_req_valid_i = 1'b0;
        check("t1.req_ready", 64'(snp_req_ready_o), 64'd0);
        check("t1.ac_valid",  64'(ac_valid_o),      64'b10);
        check("t1.ac_addr",   ac_addr_o,            64'h1000);
        check("t1.ac_snoop",  64'(ac_snoop_o),      64'd1);
        check("t1.cr_ready0", 64'(cr_ready_o),      64'b00);
        ac_ready_i = 2'b10;
        tick();
        ac_ready_i = 2'b00;
        check("t1.ac_valid_done", 64'(ac_valid_o), 64'b00);
        check("t1.cr_ready",      64'(cr_ready_o), 64'b10);
        cr_valid_i = 2'b10;
        cr_resp_i  = {5'b01001, 5'b00000};
        tick();
        cr_valid_i = 2'b00;
        check("t1.cr_ready_after", 64'(cr_ready_o), 64'b00);
        check_resp("t1", 1'b1, 5'b01001, 1'b1, 1'b1);
        snp_resp_ready_i = 1'b1;
        tick();
        snp_resp_ready_i = 1'b0;
        check("t1.idle_ready", 64'(snp_req_ready_o),  64'd1);
        check("t1.idle_rvld",  64'(snp_resp_valid_o), 64'd0);

        // T2: both masters, master0 AC ready delayed
        request(64'h0000_0000_dead_b000, 4'b0111, 2'b00);
        tick();
        snp_req_valid_i = 1'b0;
        check("t2.ac_valid", 64'(ac_valid_o), 64'b11);
        ac_ready_i = 2'b10;
        tick();
        ac_ready_i = 2'b00;
        check("t2.ac_valid_m0", 64'(ac_valid_o), 64'b01);
        check("t2.cr_ready_m1", 64'(cr_ready_o), 64'b10);
        cr_valid_i = 2'b10;
        cr_resp_i  = {5'b00100, 5'b00000};
        tick();
        cr_valid_i = 2'b00;
        check("t2.cr_ready_none", 64'(cr_ready_o),       64'b00);
        check("t2.early_rvld",    64'(snp_resp_valid_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2.ac_hold", 64'(ac_valid_o), 64'b01);
        end
        ac_ready_i = 2'b01;
        tick();
        ac_ready_i = 2'b00;
        check("t2.ac_valid_done", 64'(ac_valid_o),       64'b00);
        check("t2.cr_ready_m0",   64'(cr_ready_o),       64'b01);
        check("t2.mid_rvld",      64'(snp_resp_valid_o), 64'd0);
        cr_valid_i = 2'b01;
        cr_resp_i  = {5'b00000, 5'b10001};
        tick();
        cr_valid_i = 2'b00;
        check_resp("t2", 1'b1, 5'b10101, 1'b1, 1'b0);
        tick();
        check_resp("t2.hold", 1'b1, 5'b10101, 1'b1, 1'b0);
        check("t2.hold_req_ready", 64'(snp_req_ready_o), 64'd0);
        snp_resp_ready_i = 1'b1;
        tick();
        snp_resp_ready_i = 1'b0;
        check("t2.idle_ready", 64'(snp_req_ready_o), 64'd1);

        // T3: CR raised with AC handshake; both masters DataTransfer together
        request(64'h40, 4'b0001, 2'b00);
        tick();
        snp_req_valid_i = 1'b0;
        ac_ready_i = 2'b11;
        cr_valid_i = 2'b11;
        cr_resp_i  = {5'b00011, 5'b00001};
        check("t3.cr_ready_same", 64'(cr_ready_o), 64'b00);
        tick();
        ac_ready_i = 2'b00;
        check("t3.cr_ready_next", 64'(cr_ready_o),       64'b11);
        check("t3.no_rvld",       64'(snp_resp_valid_o), 64'd0);
        tick();
        cr_valid_i = 2'b00;
        check_resp("t3", 1'b1, 5'b00011, 1'b1, 1'b0);
        snp_resp_ready_i = 1'b1;
        tick();
        snp_resp_ready_i = 1'b0;

        // T4: every master excluded
        request(64'h80, 4'b0001, 2'b11);
        tick();
        snp_req_valid_i = 1'b0;
        check("t4.ac_valid", 64'(ac_valid_o), 64'b00);
        check_resp("t4", 1'b1, 5'b00000, 1'b0, 1'b0);
        snp_resp_ready_i = 1'b1;
        tick();
        snp_resp_ready_i = 1'b0;
        check("t4.ac_valid_after", 64'(ac_valid_o), 64'b00);

        // T5: reset pulsed during SNOOP, then a clean 4-cycle transaction
        request(64'hc0, 4'b0001, 2'b00);
        tick();
        snp_req_valid_i = 1'b0;
        check("t5.ac_valid", 64'(ac_valid_o), 64'b11);
        rst_ni = 1'b0;
        #1;
        check("t5.rst_ac_valid",  64'(ac_valid_o),      64'd0);
        check("t5.rst_req_ready", 64'(snp_req_ready_o), 64'd0);
        check("t5.rst_ac_addr",   ac_addr_o,            64'd0);
        check_resp("t5.rst", 1'b0, 5'b0, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b1;
        tick();
        check("t5.rel_ready", 64'(snp_req_ready_o),  64'd1);
        check("t5.rel_rvld",  64'(snp_resp_valid_o), 64'd0);
        check("t5.rel_ac",    64'(ac_valid_o),       64'd0);
        request(64'h2000, 4'b0111, 2'b10);
        ac_ready_i       = 2'b01;
        cr_valid_i       = 2'b01;
        cr_resp_i        = {5'b00000, 5'b00110};
        snp_resp_ready_i = 1'b1;
        tick();
        snp_req_valid_i = 1'b0;
        check("t5.c1_ac_valid", 64'(ac_valid_o),  64'b01);
        check("t5.c1_ac_addr",  ac_addr_o,        64'h2000);
        check("t5.c1_ac_snoop", 64'(ac_snoop_o),  64'd7);
        check("t5.c1_cr_ready", 64'(cr_ready_o),  64'b00);
        tick();
        check("t5.c2_ac_valid", 64'(ac_valid_o), 64'b00);
        check("t5.c2_cr_ready", 64'(cr_ready_o), 64'b01);
        tick();
        check_resp("t5.c3", 1'b1, 5'b00110, 1'b0, 1'b0);
        tick();
        check("t5.c4_req_ready", 64'(snp_req_ready_o),  64'd1);
        check("t5.c4_rvld",      64'(snp_resp_valid_o), 64'd0);
        ac_ready_i       = 2'b00;
        cr_valid_i       = 2'b00;
        snp_resp_ready_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ace_snoop_fanout.md
# ace_snoop_fanout

Sequences one ACE snoop transaction at a time from the coherency interconnect out to NoMst cached masters. It broadcasts the snoop on each target master's AC channel and collects every CRRESP. It then returns one merged snoop response plus the index of the master that will supply CD data. It sits between the CCU's snoop request logic and the per-master AC/CR channels; CD data forwarding is handled by a separate block using `data_src_o`.

## Interface
Parameters:
- NoMst, 2, number of snooped masters (≥1)
- AddrWidth, 64, AC address width
- IdxWidth, max(1,$clog2(NoMst)), derived, width of master index

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- snp_req_valid_i  in  1  snoop request valid
- snp_req_ready_o  out  1  request accepted
- snp_addr_i  in  AddrWidth  snoop address
- snp_snoop_i  in  4  ACSNOOP (ace_pkg::arsnoop_t)
- snp_excl_i  in  NoMst  masters not to snoop (initiator); bit=1 skips master
- ac_valid_o  out  NoMst  per-master AC valid
- ac_ready_i  in  NoMst  per-master AC ready
- ac_addr_o  out  AddrWidth  AC address, shared by all masters
- ac_snoop_o  out  4  AC snoop type, shared
- cr_valid_i  in  NoMst  per-master CR valid
- cr_ready_o  out  NoMst  per-master CR ready
- cr_resp_i  in  5*NoMst  CRRESP, master i at [5i+4:5i]
- snp_resp_valid_o  out  1  merged response valid
- snp_resp_ready_i  in  1  merged response accepted
- snp_resp_o  out  5  merged CRRESP
- data_src_valid_o  out  1  some master signalled DataTransfer
- data_src_o  out  IdxWidth  lowest-index master with DataTransfer

## Operation
- CRRESP bits: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- FSM states: IDLE, SNOOP, RESP. After reset the FSM is in IDLE.
- IDLE:
  - snp_req_ready_o=1.
  - On handshake, register addr and snoop type and set target mask = ~snp_excl_i.
  - Clear ac_done, cr_done and the merge accumulator.
  - If the target mask is nonzero, go to SNOOP. If it is all-zero, go straight to RESP with snp_resp_o=0 and data_src_valid_o=0.
- SNOOP:
  - ac_valid_o[i] = target[i] & ~ac_done[i]. Masters handshake independently. ac_done[i] sets on ac_valid_o[i]&ac_ready_i[i].
  - ac_addr_o and ac_snoop_o hold the registered values throughout SNOOP.
  - cr_ready_o[i] = ac_done[i] & ~cr_done[i], using the registered ac_done. A CR presented in the same cycle as its AC handshake is not accepted.
  - On a CR handshake:
    - cr_done[i] sets.
    - The response is OR-merged into the accumulator, all five bits.
    - If bit0 is set and no source is recorded yet, record data_src=i. If several masters assert DataTransfer in one cycle, the lowest index wins.
  - When cr_done == target mask after an update, go to RESP.
- RESP:
  - snp_resp_valid_o=1 with the accumulator on snp_resp_o, plus data_src_valid_o/data_src_o.
  - These outputs hold stable until snp_resp_ready_i, then the FSM returns to IDLE.
- Only one snoop is in flight. snp_req_ready_o=0 outside IDLE.

## Timing
- Reset values: snp_req_ready_o=0 while rst_ni=0 and 1 after release (IDLE). All other outputs reset to 0: ac_valid_o, cr_ready_o, snp_resp_valid_o, snp_resp_o, data_src_valid_o, data_src_o, ac_addr_o, ac_snoop_o.
- Request handshake at cycle 0 leads to ac_valid_o asserted from cycle 1. All outputs are registered or decoded from state registers only; no combinational path from *_valid_i/ready_i to any output.
- The AC handshake for master i at cycle k puts cr_ready_o[i] high from cycle k+1.
- When the last CR handshake is at cycle n, snp_resp_valid_o is high from cycle n+1.
- A response handshake at cycle m gives snp_req_ready_o=1 at m+1. The minimum request-to-request period for a single target with ready always high is 4 cycles.
- AC valid must not drop before ready. ac_valid_o[i] stays high until its handshake regardless of other masters.
- Asserting rst_ni=0 mid-transaction aborts immediately. All outputs go to reset values, the accumulated state is lost, and no response is issued.

## Test plan
- NoMst=2, excl=2'b01, snoop=ReadShared (4'b0001), addr=0x1000:
  - Only ac_valid_o[1] rises at cycle 1 with ac_addr_o=0x1000.
  - CR resp 5'b01001 is returned; snp_resp_o=5'b01001, data_src_valid_o=1, data_src_o=1.
- NoMst=2, no exclusions:
  - Master0 AC ready is delayed 5 cycles and master1 is ready immediately. Master1 CR is 5'b00100 and master0 CR is 5'b10001.
  - Required: snp_resp_o=5'b10101, data_src_o=0. Response is valid only after both CRs are accepted.
- Both masters return DataTransfer in the same cycle: data_src_o=0, snp_resp_o bit0=1.
- excl=all ones: no ac_valid_o ever, and snp_resp_valid_o=1 with snp_resp_o=0 at cycle 1 after the request.
- cr_valid_i[0] is raised in the same cycle as its AC handshake: cr_ready_o[0]=0 in that cycle and the CR is accepted the next cycle.
- rst_ni is pulsed low during SNOOP: all outputs are 0 immediately. After release, a new request completes normally and no stale response appears.
